// File: rtl/wimax_deinterleaver_if.sv
// Serial bit-stream handshake bundle for the WiMAX de-interleaver.
// The slave modport is the de-interleaver; the master modport is the surrounding logic.
interface wimax_deinterleaver_if;
   logic serial_in;
   logic valid_in;
   logic ready_out;
   logic data_out;
   logic valid_out;
   logic ready_in;

   modport slave (
      input  serial_in,
      input  valid_in,
      output ready_out,
      output data_out,
      output valid_out,
      input  ready_in
   );

   modport master (
      output serial_in,
      output valid_in,
      input  ready_out,
      input  data_out,
      input  valid_out,
      output ready_in
   );
endinterface

// File: rtl/wimax_deinterleaver.sv
// Ping-pong block de-interleaver that inverts the IEEE 802.16 two-step interleaver.
// Optional macro DEINT_BLK_CNT_EN adds a 16-bit completed-read-block counter output.
module wimax_deinterleaver #(
   parameter int NCBPS = 192,
   parameter int NCPC  = 2,
   parameter int D     = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   wimax_deinterleaver_if.slave  bus
`ifdef DEINT_BLK_CNT_EN
   ,
   output logic [15:0]           blk_cnt
`endif
);

   localparam int S  = (NCPC / 2 < 1) ? 1 : NCPC / 2;
   localparam int AW = $clog2(NCBPS);

   // Write-address table for every received index j, folded to constants at elaboration.
   function automatic logic [NCBPS*AW-1:0] build_perm();
      logic [NCBPS*AW-1:0] t;
      int mj;
      int kj;
      t = '0;
      for (int j = 0; j < NCBPS; j++) begin
         mj = S * (j / S) + (j + (D * j) / NCBPS) % S;
         kj = D * mj - (NCBPS - 1) * ((D * mj) / NCBPS);
         t[j*AW +: AW] = AW'(kj);
      end
      return t;
   endfunction

   localparam logic [NCBPS*AW-1:0] PERM = build_perm();

   logic [1:0][NCBPS-1:0] bank_q, bank_d;
   logic [AW-1:0]         j_q, j_d;
   logic [AW-1:0]         k_q, k_d;
   logic                  wr_sel_q, wr_sel_d;
   logic                  rd_sel_q, rd_sel_d;
   logic [1:0]            full_q, full_d;
   logic                  ready_q, ready_d;
   logic [AW-1:0]         wr_addr;
   logic                  wr_fire;
   logic                  rd_fire;
   logic                  rd_last;

   assign wr_addr = PERM[int'(j_q)*AW +: AW];
   assign wr_fire = bus.valid_in && ready_q;
   assign rd_fire = full_q[rd_sel_q] && bus.ready_in;
   assign rd_last = rd_fire && (k_q == AW'(NCBPS - 1));

   assign bus.ready_out = ready_q;
   assign bus.valid_out = full_q[rd_sel_q];
   assign bus.data_out  = full_q[rd_sel_q] & bank_q[rd_sel_q][k_q];

   always_comb begin
      j_d      = j_q;
      k_d      = k_q;
      wr_sel_d = wr_sel_q;
      rd_sel_d = rd_sel_q;
      full_d   = full_q;
      bank_d   = bank_q;
      if (wr_fire) begin
         bank_d[wr_sel_q][wr_addr] = bus.serial_in;
         if (j_q == AW'(NCBPS - 1)) begin
            j_d              = '0;
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = ~wr_sel_q;
         end else begin
            j_d = j_q + AW'(1);
         end
      end
      if (rd_fire) begin
         if (rd_last) begin
            k_d              = '0;
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = ~rd_sel_q;
         end else begin
            k_d = k_q + AW'(1);
         end
      end
      // Registered ready looks at the post-update bank so a freed bank reopens next edge.
      ready_d = ~full_d[wr_sel_d];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         j_q      <= '0;
         k_q      <= '0;
         wr_sel_q <= 1'b0;
         rd_sel_q <= 1'b0;
         full_q   <= '0;
         ready_q  <= 1'b1;
      end else begin
         j_q      <= j_d;
         k_q      <= k_d;
         wr_sel_q <= wr_sel_d;
         rd_sel_q <= rd_sel_d;
         full_q   <= full_d;
         ready_q  <= ready_d;
      end
   end

   always_ff @(posedge clk) begin
      bank_q <= bank_d;
   end

`ifdef DEINT_BLK_CNT_EN
   logic [15:0] blk_cnt_q, blk_cnt_d;

   always_comb begin
      blk_cnt_d = blk_cnt_q;
      if (rd_last) begin
         blk_cnt_d = blk_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk_cnt_q <= '0;
      end else begin
         blk_cnt_q <= blk_cnt_d;
      end
   end

   assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_wimax_deinterleaver.sv
// Directed self-checking bench for wimax_deinterleaver (default parameters, s = 1).
// Expected output order comes from the transmit-side interleaver formula, not the receive one.
module tb_wimax_deinterleaver;
   localparam int NCBPS = 192;

   logic clk;
   logic rst_n;
   int   nChecks;
   int   nFail;
   logic [15:0] expBlk;

   wimax_deinterleaver_if bus ();

`ifdef DEINT_BLK_CNT_EN
   logic [15:0] blkCnt;
`endif

   wimax_deinterleaver dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef DEINT_BLK_CNT_EN
      ,
      .blk_cnt (blkCnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nFail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic vin, input logic sin, input logic rin);
      bus.valid_in  = vin;
      bus.serial_in = sin;
      bus.ready_in  = rin;
      @(posedge clk);
      #1;
   endtask

   // Transmit interleaver for s = 1: natural bit k is sent at position 12*(k mod 16) + k/16.
   function automatic logic [NCBPS-1:0] interleave(input logic [NCBPS-1:0] orig);
      logic [NCBPS-1:0] tx;
      tx = '0;
      for (int k = 0; k < NCBPS; k++) begin
         tx[12 * (k % 16) + k / 16] = orig[k];
      end
      return tx;
   endfunction

   function automatic logic [NCBPS-1:0] randomBlock();
      logic [NCBPS-1:0] b;
      for (int i = 0; i < NCBPS; i++) begin
         b[i] = 1'($urandom_range(0, 1));
      end
      return b;
   endfunction

   task automatic sendBlock(input logic [NCBPS-1:0] tx, input logic rin);
      for (int j = 0; j < NCBPS; j++) begin
         applyStimulus(1'b1, tx[j], rin);
      end
      bus.valid_in = 1'b0;
   endtask

   task automatic drainBlock(input logic [NCBPS-1:0] orig, input string tag);
      for (int k = 0; k < NCBPS; k++) begin
         checkOutput({tag, "_valid"}, 32'(bus.valid_out), 32'd1);
         checkOutput({tag, "_data"}, 32'(bus.data_out), 32'(orig[k]));
`ifdef DEINT_BLK_CNT_EN
         if (k == NCBPS - 1) checkOutput({tag, "_blkcnt_before"}, 32'(blkCnt), 32'(expBlk));
`endif
         applyStimulus(1'b0, 1'b0, 1'b1);
      end
      expBlk = expBlk + 16'd1;
`ifdef DEINT_BLK_CNT_EN
      checkOutput({tag, "_blkcnt_after"}, 32'(blkCnt), 32'(expBlk));
`endif
   endtask

   task automatic singleOne(input int jPos, input int kPos, input string tag);
      logic [NCBPS-1:0] rxBlk;
      logic [NCBPS-1:0] expBlkBits;
      rxBlk = '0;
      rxBlk[jPos] = 1'b1;
      expBlkBits = '0;
      expBlkBits[kPos] = 1'b1;
      for (int j = 0; j < NCBPS; j++) begin
         if (j == NCBPS - 1) checkOutput({tag, "_valid_before_last"}, 32'(bus.valid_out), 32'd0);
         applyStimulus(1'b1, rxBlk[j], 1'b1);
      end
      bus.valid_in = 1'b0;
      checkOutput({tag, "_valid_after_last"}, 32'(bus.valid_out), 32'd1);
      drainBlock(expBlkBits, tag);
      checkOutput({tag, "_valid_idle"}, 32'(bus.valid_out), 32'd0);
   endtask

   logic [NCBPS-1:0] rt [4];
   logic [NCBPS-1:0] rtTx [4];
   logic [NCBPS-1:0] blkA, blkB, blkC;
   int rx;

   initial begin
      nChecks = 0;
      nFail = 0;
      expBlk = '0;
      rst_n = 1'b1;
      bus.valid_in = 1'b0;
      bus.serial_in = 1'b0;
      bus.ready_in = 1'b0;

      // Reset asserted mid-cycle takes effect without a clock edge.
      #2 rst_n = 1'b0;
      #1;
      checkOutput("reset_ready", 32'(bus.ready_out), 32'd1);
      checkOutput("reset_valid", 32'(bus.valid_out), 32'd0);
      checkOutput("reset_data", 32'(bus.data_out), 32'd0);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0);
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("post_reset_valid", 32'(bus.valid_out), 32'd0);
      checkOutput("post_reset_ready", 32'(bus.ready_out), 32'd1);
`ifdef DEINT_BLK_CNT_EN
      checkOutput("post_reset_blkcnt", 32'(blkCnt), 32'd0);
`endif

      // Single-one mapping: received index j lands at natural index k.
      singleOne(13, 17, "one_j13");
      singleOne(191, 191, "one_j191");
      singleOne(1, 16, "one_j1");
      singleOne(0, 0, "one_j0");

      // Round trip: four back-to-back blocks, both sides streaming every cycle.
      for (int b = 0; b < 4; b++) begin
         rt[b] = randomBlock();
         rtTx[b] = interleave(rt[b]);
      end
      rx = 0;
      for (int c = 0; c < 4 * NCBPS + 200; c++) begin
         if (c < 4 * NCBPS) checkOutput("rt_ready", 32'(bus.ready_out), 32'd1);
         if (rx > 0 && rx < 4 * NCBPS) checkOutput("rt_continuous", 32'(bus.valid_out), 32'd1);
         if (bus.valid_out === 1'b1 && rx < 4 * NCBPS) begin
            checkOutput("rt_data", 32'(bus.data_out), 32'(rt[rx / NCBPS][rx % NCBPS]));
            rx++;
         end
         if (c < 4 * NCBPS) applyStimulus(1'b1, rtTx[c / NCBPS][c % NCBPS], 1'b1);
         else applyStimulus(1'b0, 1'b0, 1'b1);
      end
      checkOutput("rt_count", 32'(rx), 32'(4 * NCBPS));
      checkOutput("rt_idle", 32'(bus.valid_out), 32'd0);
      expBlk = expBlk + 16'd4;
`ifdef DEINT_BLK_CNT_EN
      checkOutput("rt_blkcnt", 32'(blkCnt), 32'(expBlk));
`endif

      // Backpressure: two blocks fill both banks while the consumer is stalled.
      blkA = randomBlock();
      blkB = randomBlock();
      sendBlock(interleave(blkA), 1'b0);
      for (int j = 0; j < NCBPS; j++) begin
         checkOutput("bp_ready_open", 32'(bus.ready_out), 32'd1);
         applyStimulus(1'b1, interleave(blkB)[j], 1'b0);
      end
      checkOutput("bp_ready_dropped", 32'(bus.ready_out), 32'd0);
      checkOutput("bp_valid", 32'(bus.valid_out), 32'd1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, i[0], 1'b0);
         checkOutput("bp_data_stable", 32'(bus.data_out), 32'(blkA[0]));
         checkOutput("bp_ready_held", 32'(bus.ready_out), 32'd0);
      end
      for (int k = 0; k < NCBPS - 1; k++) begin
         checkOutput("bp_drain_data", 32'(bus.data_out), 32'(blkA[k]));
         applyStimulus(1'b0, 1'b0, 1'b1);
      end
      checkOutput("bp_ready_not_before", 32'(bus.ready_out), 32'd0);
      checkOutput("bp_last_data", 32'(bus.data_out), 32'(blkA[NCBPS - 1]));
      applyStimulus(1'b0, 1'b0, 1'b1);
      expBlk = expBlk + 16'd1;
      checkOutput("bp_ready_reopen", 32'(bus.ready_out), 32'd1);
      drainBlock(blkB, "bp_second");
      checkOutput("bp_idle", 32'(bus.valid_out), 32'd0);

      // Reset mid-block discards a complete block and a partial one.
      blkC = randomBlock();
      sendBlock(interleave(blkA), 1'b0);
      for (int j = 0; j < 100; j++) applyStimulus(1'b1, interleave(blkB)[j], 1'b0);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midrst_valid", 32'(bus.valid_out), 32'd0);
      checkOutput("midrst_ready", 32'(bus.ready_out), 32'd1);
      checkOutput("midrst_data", 32'(bus.data_out), 32'd0);
      #1 rst_n = 1'b1;
      expBlk = '0;
      applyStimulus(1'b0, 1'b0, 1'b0);
`ifdef DEINT_BLK_CNT_EN
      checkOutput("midrst_blkcnt", 32'(blkCnt), 32'd0);
`endif
      sendBlock(interleave(blkC), 1'b0);
      drainBlock(blkC, "midrst_fresh");
      checkOutput("midrst_idle", 32'(bus.valid_out), 32'd0);

`ifdef DEINT_BLK_CNT_EN
      // Counter wrap from 0xFFFF on the next completed block.
      force dut.blk_cnt_q = 16'hFFFF;
      applyStimulus(1'b0, 1'b0, 1'b0);
      release dut.blk_cnt_q;
      checkOutput("wrap_forced", 32'(blkCnt), 32'hFFFF);
      expBlk = 16'hFFFF;
      sendBlock(interleave(blkA), 1'b1);
      drainBlock(blkA, "wrap");
      checkOutput("wrap_zero", 32'(blkCnt), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFail);
      $finish;
   end
endmodule

// File: doc/wimax_deinterleaver.md
Name: wimax_deinterleaver

Overview:
- Receive-side block-wise de-interleaver for the WiMAX PHY; exact inverse of the transmit interleaver (IEEE 802.16 two-step permutation).
- Sits between the QPSK demapper output (hard bits, serial) and the Viterbi/FEC decoder input.
- Accepts one coded bit per handshake and restores coded-bit order per Ncbps block.
- Ping-pong double buffer: one bank fills while the other drains.

Parameters:
- Ncbps, 192, coded bits per block/OFDM symbol; must be a multiple of d.
- Ncpc, 2, coded bits per subcarrier.
- s, Ncpc/2 (floor, minimum 1), second-permutation span.
- d, 16, interleaver column count.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- serial_in  input  1  received coded bit, interleaved order.
- valid_in  input  1  serial_in valid.
- ready_out  output  1  block can accept a bit.
- data_out  output  1  de-interleaved bit, natural order k.
- valid_out  output  1  data_out valid.
- ready_in  input  1  downstream accepts data_out.

Behaviour:
- Reset values: ready_out=1, valid_out=0, data_out=0. Write counter j=0, read counter k=0, wr_sel=0, rd_sel=0, both bank-full flags=0. Bank contents are not cleared.
- Write side:
  - A bit is accepted when valid_in && ready_out.
  - The bit is stored in bank[wr_sel] at kj. mj = s*floor(j/s) + (j + floor(d*j/Ncbps)) mod s. kj = d*mj - (Ncbps-1)*floor(d*mj/Ncbps).
  - For the defaults (s=1) this reduces to kj = 16*(j mod 12) + floor(j/12).
- Write wrap: on accepting j = Ncbps-1, set full[wr_sel], toggle wr_sel, and set j=0.
- ready_out is registered and equals !full[wr_sel] using post-update state.
- Read side:
  - valid_out = full[rd_sel]; data_out = bank[rd_sel][k].
  - On valid_out && ready_in, k increments.
  - On transferring k = Ncbps-1: clear full[rd_sel], toggle rd_sel, set k=0.
- Latency: the last bit of a block accepted at edge T gives valid_out=1 with k=0 from edge T onward, i.e. valid in cycle T+1.
- Throughput: sustained one bit per clock in and out with no bubbles when both sides stream continuously.
- Backpressure: while ready_in=0, data_out and k hold. Both banks full forces ready_out=0 until a bank drains.
- Simultaneous events:
  - Read completion freeing bank X in the same cycle the writer is blocked on X: ready_out rises at the next edge; no bit is lost or duplicated.
  - Write completion and read completion in the same cycle: both flag updates apply independently.
- Partial blocks are never emitted. A block becomes readable only after all Ncbps bits are written.
- Reset mid-operation: all counters, selects and flags return to reset values immediately and asynchronously. Partially written and partially read blocks are discarded.
- Address arithmetic: counters are $clog2(Ncbps) bits wide. The permutation uses elaboration constants only, with no runtime divider.

Optional Feature:
- Macro: DEINT_BLK_CNT_EN.
- Defined:
  - Adds output blk_cnt[15:0], reset 0.
  - Increments by 1 on each completed read block (transfer of k = Ncbps-1); wraps 0xFFFF->0.
- Undefined: port absent; no counter logic.

Test Plan:
- Reset: assert rst_n=0 mid-clock -> immediately ready_out=1, valid_out=0, data_out=0; hold for 5 cycles with valid_in=1 -> nothing stored.
- Single-one mapping: 192 bits, only j=13 equal to 1, ready_in=1 -> valid_out rises the cycle after bit 191; the only 1 appears at output index k=17. Repeat with j=191 -> k=191, and j=1 -> k=16.
- Round trip: 4 random 192-bit blocks through the transmit interleaver then this block, valid_in=1 and ready_in=1 every cycle -> output bits equal the originals in order; no bubbles after the first block; valid_out is continuous for 768 cycles.
- Backpressure: ready_in=0 while 384 bits are offered -> ready_out drops after bit 383; valid_out=1 with data_out stable. Raise ready_in for 1 cycle -> ready_out=1 on the next cycle and not before.
- Reset mid-block: apply reset after 100 bits of block 2 -> valid_out=0 and ready_out=1. A fresh 192-bit block then emerges correctly with k starting at 0.
- DEINT_BLK_CNT_EN build: stream 3 blocks -> blk_cnt = 1, 2, 3, each step coinciding with the last output bit of a block. Force the counter to 0xFFFF, complete a block -> blk_cnt = 0.
